// File: rtl/iir_pkg.sv
// iir_pkg: shared coefficient addresses, FSM encoding and output saturation for the biquad
package iir_pkg;
  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Clamp v to the signed dw-bit range; ovf flags any clamp.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v, input int dw,
                                                   output logic ovf);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    ovf = (v > hi) || (v < lo);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/iir_mac.sv
// iir_mac: signed sample x coefficient multiplier feeding a loadable accumulator
module iir_mac #(
  parameter int DW = 12,
  parameter int CW = 12,
  parameter int AW = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 acc_en_i,
  input  logic signed [AW-1:0] load_val_i,
  input  logic signed [DW-1:0] data_i,
  input  logic signed [CW-1:0] coef_i,
  output logic signed [AW-1:0] acc_o
);
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0] acc_q;
  assign prod  = data_i * coef_i;
  assign acc_o = acc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (load_i) acc_q <= load_val_i;
    else if (acc_en_i) acc_q <= acc_q + AW'(prod);
  end
endmodule

// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: direct-form-I biquad sharing one multiplier over a 5-tap MAC per sample
module iir_biquad_seq
  import iir_pkg::*;
#(
  parameter int DW   = 12,
  parameter int CW   = 12,
  parameter int FRAC = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic                 din_ready,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dout,
  input  logic                 coef_wr,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 clear,
  output logic                 sat_flag
);
  localparam int AW = DW + CW + 3;
  localparam logic signed [AW-1:0] RND = AW'(1 << (FRAC - 1));
  localparam logic signed [CW-1:0] ONE = CW'(1 << FRAC);

  state_t state_q;
  logic [2:0] tap_q;
  logic signed [CW-1:0] coef_q [5];
  logic signed [CW-1:0] shad_q [5];
  logic signed [DW-1:0] x0_q, x1_q, x2_q, y1_q, y2_q, dout_q;
  logic dout_valid_q, sat_q, ovf, accept;
  logic signed [CW-1:0] mul_c;
  logic signed [DW-1:0] mul_x;
  logic signed [AW-1:0] acc, acc_sh;
  logic signed [63:0] sat_w;

  assign accept     = state_q == IDLE && din_valid && !clear;
  assign din_ready  = state_q == IDLE;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign sat_flag   = sat_q;

  always_comb begin
    mul_c  = tap_q == 3'd0 ? shad_q[0] : tap_q == 3'd1 ? shad_q[1] :
             tap_q == 3'd2 ? shad_q[2] : tap_q == 3'd3 ? shad_q[3] : shad_q[4];
    mul_x  = tap_q == 3'd0 ? x0_q : tap_q == 3'd1 ? x1_q :
             tap_q == 3'd2 ? x2_q : tap_q == 3'd3 ? y1_q : y2_q;
    acc_sh = acc >>> FRAC;
    sat_w  = sat_trunc(64'(acc_sh), DW, ovf);
  end

  iir_mac #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .acc_en_i   (state_q == MAC && !clear),
    .load_val_i (RND),
    .data_i     (mul_x),
    .coef_i     (mul_c),
    .acc_o      (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      {x0_q, x1_q, x2_q, y1_q, y2_q, dout_q} <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        coef_q[i] <= i == 0 ? ONE : '0;
        shad_q[i] <= i == 0 ? ONE : '0;
      end
    end else begin
      if (coef_wr && coef_addr <= COEF_A2) coef_q[coef_addr] <= coef_data;
      dout_valid_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        {x0_q, x1_q, x2_q, y1_q, y2_q} <= '0;
        sat_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (din_valid) begin
            x0_q    <= din;
            shad_q  <= coef_q;
            tap_q   <= '0;
            state_q <= MAC;
          end
          MAC: begin
            tap_q   <= tap_q + 3'd1;
            state_q <= tap_q == 3'd4 ? OUT : MAC;
          end
          default: begin
            dout_q       <= DW'(sat_w);
            dout_valid_q <= 1'b1;
            sat_q        <= sat_q | ovf;
            x2_q         <= x1_q;
            x1_q         <= x0_q;
            y2_q         <= y1_q;
            y1_q         <= DW'(sat_w);
            state_q      <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb_iir_biquad_seq: directed vectors with a queue scoreboard checked by an independent monitor
module tb_iir_biquad_seq;
  logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, coef_wr = 1'b0, clear = 1'b0;
  logic signed [11:0] din = '0, coef_data = '0;
  logic [2:0] coef_addr = '0;
  logic din_ready, dout_valid, sat_flag;
  logic signed [11:0] dout;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int exp_q[$], sat_q[$], hs_q[$];
  int me, ms, mh;
  int m_x1, m_x2, m_y1, m_y2, m_sat;
  int m_c[5];

  iir_biquad_seq #(.DW(12), .CW(12), .FRAC(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .clear      (clear),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dout: got pulse with dout %0d, expected none", dout);
      end else begin
        me = exp_q.pop_front();
        ms = sat_q.pop_front();
        mh = hs_q.pop_front();
        check("dout", int'(dout), me);
        if (ms >= 0) check("sat_flag", int'(sat_flag), ms);
        check("latency", cyc - mh, 6);
      end
    end
  end

  function automatic int model(input int x);
    int acc, y;
    acc = m_c[0] * x + m_c[1] * m_x1 + m_c[2] * m_x2 + m_c[3] * m_y1 + m_c[4] * m_y2 + 512;
    y = acc >>> 10;
    if (y > 2047) begin y = 2047; m_sat = 1; end
    else if (y < -2048) begin y = -2048; m_sat = 1; end
    m_x2 = m_x1; m_x1 = x; m_y2 = m_y1; m_y1 = y;
    return y;
  endfunction

  task automatic wr(input int a, input int d);
    @(negedge clk);
    coef_wr = 1'b1; coef_addr = 3'(a); coef_data = 12'(d);
    @(negedge clk);
    coef_wr = 1'b0;
    m_c[a] = d;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0; m_sat = 0;
  endtask

  task automatic send(input int v, input bit push, input int e, input int s);
    int n = 0;
    @(negedge clk);
    din_valid = 1'b1; din = 12'(v);
    while (!din_ready && n < 50) begin @(negedge clk); n++; end
    if (!din_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: din_ready stayed 0, expected 1");
      din_valid = 1'b0;
      return;
    end
    if (push) begin exp_q.push_back(e); sat_q.push_back(s); hs_q.push_back(cyc + 1); end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d outputs missing, expected 0", exp_q.size());
      exp_q.delete(); sat_q.delete(); hs_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, y;
    m_c = '{1024, 0, 0, 0, 0};
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0; m_sat = 0;
    repeat (3) @(negedge clk);
    check("rst_din_ready", int'(din_ready), 1);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    rst_n = 1'b1;
    // pass-through defaults and handshake timing
    send(100, 1, 100, 0);
    n = 0;
    while (!din_ready && n < 20) begin n++; @(negedge clk); end
    check("busy_cycles", n, 6);
    send(-200, 1, -200, 0);
    send(2047, 1, 2047, 0);
    drain();
    // resonant impulse response; the third output already exceeds the 12-bit range
    wr(3, 1911); wr(4, -986); do_clear();
    for (int i = 0; i < 64; i++) begin
      y = model(i == 0 ? 1000 : 0);
      send(i == 0 ? 1000 : 0, 1, i == 0 ? 1000 : i == 1 ? 1866 : i == 2 ? 2047 : y, m_sat);
    end
    drain();
    // saturation both ways, sticky flag and its clear
    wr(1, 1024); wr(2, 1024); wr(3, 0); wr(4, 0); do_clear();
    send(2047, 1, 2047, 0); send(2047, 1, 2047, 1); send(2047, 1, 2047, 1);
    drain();
    do_clear();
    check("sat_after_clear", int'(sat_flag), 0);
    send(-2048, 1, -2048, 0); send(-2048, 1, -2048, 1); send(-2048, 1, -2048, 1);
    drain();
    // coefficient write while a sample is in flight
    wr(1, 0); wr(2, 0); do_clear();
    send(400, 1, 400, 0);
    wr(0, 512);
    send(400, 1, 200, 0);
    drain();
    // clear aborts a sample and flushes history (y1=200, x1=400 before this)
    wr(0, 1024); wr(3, 1911);
    send(500, 0, 0, 0);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_din_ready", int'(din_ready), 1);
    repeat (10) @(negedge clk);
    send(300, 1, 300, 0);
    drain();
    // asynchronous reset mid-MAC restores pass-through
    wr(0, 512);
    send(700, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_din_ready", int'(din_ready), 1);
    check("arst_dout_valid", int'(dout_valid), 0);
    check("arst_dout", int'(dout), 0);
    check("arst_sat_flag", int'(sat_flag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(55, 1, 55, 0);
    drain();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
